imem_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the single-cycle core's instruction memory. It accepts a little-endian byte stream on a valid/ready interface, assembles 32-bit instruction words, and drives the instruction memory write port. It holds the core in reset until the complete image has been written. The top level gates the core with `rst | core_rst`.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/byte_packer.sv | 32 +++
 rtl/imem_loader.sv | 108 ++++++++++
 tb/tb_imem_loader.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Imported by the byte packer and the loader top.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
    S_DATA = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } loader_state_t;

  localparam int LEN_BYTES  = 4;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// Assembles four little-endian bytes into a 32-bit word; the first byte of a
// group lands in word[7:0]. Shared by the length field and the data words.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  in_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [23:0] sbuf;

  // Bytes enter at the top and shift down, so after three pushes the
  // oldest byte sits in sbuf[7:0].
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt  <= 2'd0;
      sbuf <= 24'd0;
    end else if (push) begin
      cnt  <= cnt + 2'd1;
      sbuf <= {in_byte, sbuf[23:8]};
    end
  end

  assign word_valid = push && (cnt == 2'(WORD_BYTES - 1));
  assign word       = {in_byte, sbuf};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: reads a length-prefixed little-endian byte stream, writes the
// words into instruction memory and releases core reset once the image is in.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wd,
  output logic        core_rst,
  output logic        done,
  output logic        error,
  output logic [1:0]  dbg_state
);

  // Handshake: a byte moves only on a rising edge where in_valid && in_ready.
  // in_ready is combinational from state and rst; every other output is a flop.

  localparam logic [32:0] DEPTH = 33'd1 << ADDR_WIDTH;

  loader_state_t         state, next_state;
  logic [31:0]           len_q;
  logic [ADDR_WIDTH:0]   word_idx;
  logic                  hs;
  logic                  pk_clear;
  logic                  pk_valid;
  logic [31:0]           pk_word;
  logic                  last_word;

  assign hs        = in_valid && in_ready;
  assign pk_clear  = rst || (state != next_state);
  assign last_word = ((32'(word_idx) + 32'd1) == len_q);

  byte_packer u_packer (
    .clk        (clk),
    .clear      (pk_clear),
    .push       (hs),
    .in_byte    (in_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_LEN;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_LEN: begin
        if (pk_valid) begin
          if (pk_word == 32'd0)                next_state = S_DONE;
          else if ({1'b0, pk_word} > DEPTH)    next_state = S_ERR;
          else                                 next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (pk_valid && last_word) next_state = S_DONE;
      end
      S_DONE:  next_state = S_DONE;
      S_ERR:   next_state = S_ERR;
      default: next_state = S_LEN;
    endcase
  end

  always_comb begin
    in_ready  = !rst && (state == S_LEN || state == S_DATA);
    dbg_state = state;
  end

  // word_idx is one bit wider than the address so a full DEPTH-word image
  // can be counted without wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= 32'd0;
      word_idx <= '0;
      im_we    <= 1'b0;
      im_addr  <= 32'd0;
      im_wd    <= 32'd0;
      done     <= 1'b0;
      error    <= 1'b0;
      core_rst <= 1'b1;
    end else begin
      im_we <= 1'b0;
      if (state == S_LEN) begin
        word_idx <= '0;
        if (pk_valid) len_q <= pk_word;
      end
      if (state == S_DATA && pk_valid) begin
        im_we    <= 1'b1;
        im_wd    <= pk_word;
        im_addr  <= 32'({word_idx, 2'b00});
        word_idx <= word_idx + 1'b1;
      end
      done     <= (state == S_DONE);
      error    <= (state == S_ERR);
      core_rst <= (state != S_DONE);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two-word load, empty and oversize images,
// length boundary, bubbles, reset mid-load and post-done traffic.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wd;
  logic        core_rst;
  logic        done;
  logic        error;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [31:0] exp_q[$];

  logic [7:0] two_word[12] = '{8'h02, 8'h00, 8'h00, 8'h00,
                               8'h13, 8'h05, 8'h50, 8'h00,
                               8'h93, 8'h05, 8'hA0, 8'h00};

  imem_loader #(.ADDR_WIDTH(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wd     (im_wd),
    .core_rst  (core_rst),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // write monitor, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (im_we) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_wd);
      wr_cyc.push_back(cyc);
    end
  end

  // driver tasks
  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit accepted = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        accepted = 1;
      end
    end
    if (!accepted) begin
      checks++;
      failures++;
      $display("FAIL send_byte timeout: byte %02h not accepted, required acceptance within 20 cycles", b);
    end
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++;
    if ({im_we, im_addr, im_wd} !== 65'd0) begin
      failures++; $display("FAIL reset_write_port: got we=%b addr=%08h wd=%08h want 0/0/0", im_we, im_addr, im_wd);
    end
    checks++;
    if ({done, error, core_rst} !== 3'b001) begin
      failures++; $display("FAIL reset_status: got done=%b error=%b core_rst=%b want 0/0/1", done, error, core_rst);
    end
    checks++;
    if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic test_two_word();
    apply_reset();
    for (int i = 0; i < 12; i++) send_byte(two_word[i]);
    in_valid = 1'b0;
    checks++;
    if ({im_we, im_addr, im_wd} !== {1'b1, 32'h4, 32'h00A00593}) begin
      failures++; $display("FAIL two_word_last_pulse: got we=%b addr=%08h wd=%08h want 1/00000004/00a00593", im_we, im_addr, im_wd);
    end
    checks++;
    if ({done, core_rst, in_ready} !== 3'b010) begin
      failures++; $display("FAIL two_word_pre_done: got done=%b core_rst=%b in_ready=%b want 0/1/0", done, core_rst, in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({im_we, done, core_rst} !== 3'b010) begin
      failures++; $display("FAIL two_word_done: got we=%b done=%b core_rst=%b want 0/1/0", im_we, done, core_rst);
    end
    exp_q = '{32'h00500513, 32'h00A00593};
    checks++;
    if (wr_data.size() !== 2) begin
      failures++; $display("FAIL two_word_count: got %0d writes want 2", wr_data.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wr_addr[i] !== 32'(i * 4) || wr_data[i] !== exp_q[i]) begin
          failures++; $display("FAIL two_word_write%0d: got addr=%08h wd=%08h want %08h/%08h", i, wr_addr[i], wr_data[i], i * 4, exp_q[i]);
        end
      end
      checks++;
      if (wr_cyc[1] - wr_cyc[0] !== 4) begin
        failures++; $display("FAIL two_word_spacing: got %0d cycles between writes want 4", wr_cyc[1] - wr_cyc[0]);
      end
    end
  endtask

  task automatic test_post_done();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, im_we, done, core_rst} !== 4'b0010) begin
        failures++; $display("FAIL post_done_%0d: got ready=%b we=%b done=%b core_rst=%b want 0/0/1/0", i, in_ready, im_we, done, core_rst);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (wr_data.size() !== 2) begin failures++; $display("FAIL post_done_writes: got %0d want 2", wr_data.size()); end
  endtask

  task automatic test_empty();
    apply_reset();
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    in_valid = 1'b0;
    checks++;
    if ({done, core_rst, in_ready} !== 3'b010) begin
      failures++; $display("FAIL empty_pre_done: got done=%b core_rst=%b in_ready=%b want 0/1/0", done, core_rst, in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({done, core_rst, in_ready, error} !== 4'b1000) begin
      failures++; $display("FAIL empty_done: got done=%b core_rst=%b in_ready=%b error=%b want 1/0/0/0", done, core_rst, in_ready, error);
    end
    checks++;
    if (wr_data.size() !== 0) begin failures++; $display("FAIL empty_writes: got %0d want 0", wr_data.size()); end
  endtask

  task automatic test_oversize();
    apply_reset();
    send_byte(8'h01); send_byte(8'h04); send_byte(8'h00); send_byte(8'h00);
    in_valid = 1'b0;
    checks++;
    if (error !== 1'b0) begin failures++; $display("FAIL oversize_early: got error=%b want 0", error); end
    @(posedge clk);
    #1;
    checks++;
    if ({error, in_ready, core_rst, done} !== 4'b1010) begin
      failures++; $display("FAIL oversize_error: got error=%b in_ready=%b core_rst=%b done=%b want 1/0/1/0", error, in_ready, core_rst, done);
    end
    in_valid = 1'b1;
    in_data = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (wr_data.size() !== 0 || error !== 1'b1) begin
      failures++; $display("FAIL oversize_sticky: got writes=%0d error=%b want 0/1", wr_data.size(), error);
    end
  endtask

  task automatic test_len_depth();
    apply_reset();
    send_byte(8'h00); send_byte(8'h04); send_byte(8'h00); send_byte(8'h00);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, error, done, dbg_state} !== {3'b100, 2'd1}) begin
      failures++; $display("FAIL len_depth_accept: got ready=%b error=%b done=%b state=%0d want 1/0/0/1", in_ready, error, done, dbg_state);
    end
  endtask

  task automatic test_bubbles();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      send_byte(two_word[i]);
      if (i % 2 == 1) idle_cycle();
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q = '{32'h00500513, 32'h00A00593};
    checks++;
    if (wr_data.size() !== 2 || done !== 1'b1 || core_rst !== 1'b0) begin
      failures++; $display("FAIL bubbles_status: got writes=%0d done=%b core_rst=%b want 2/1/0", wr_data.size(), done, core_rst);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wr_addr[i] !== 32'(i * 4) || wr_data[i] !== exp_q[i]) begin
          failures++; $display("FAIL bubbles_write%0d: got addr=%08h wd=%08h want %08h/%08h", i, wr_addr[i], wr_data[i], i * 4, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 6; i++) send_byte(two_word[i]);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({im_we, core_rst, done, dbg_state} !== {3'b010, 2'd0}) begin
      failures++; $display("FAIL mid_reset_state: got we=%b core_rst=%b done=%b state=%0d want 0/1/0/0", im_we, core_rst, done, dbg_state);
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) send_byte(two_word[i]);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    exp_q = '{32'h00500513, 32'h00A00593};
    checks++;
    if (wr_data.size() !== 2 || done !== 1'b1 || core_rst !== 1'b0) begin
      failures++; $display("FAIL mid_reload_status: got writes=%0d done=%b core_rst=%b want 2/1/0", wr_data.size(), done, core_rst);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wr_addr[i] !== 32'(i * 4) || wr_data[i] !== exp_q[i]) begin
          failures++; $display("FAIL mid_reload_write%0d: got addr=%08h wd=%08h want %08h/%08h", i, wr_addr[i], wr_data[i], i * 4, exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    test_reset();
    test_two_word();
    test_post_done();
    test_empty();
    test_oversize();
    test_len_depth();
    test_bubbles();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
